// File: rtl/multicycle_exec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multicycle_exec_ctrl
// Purpose  : Shared launch/stall/capture controller for long-latency EX units,
//            with latency timeout, illegal-select error path and flush abort.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_exec_ctrl #(
  parameter int WIDTH   = 64,
  parameter int N_UNITS = 2,
  parameter int SEL_W   = 2,
  parameter int MAX_LAT = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  input  logic [SEL_W-1:0]         issue_sel,
  input  logic [WIDTH-1:0]         issue_a,
  input  logic [WIDTH-1:0]         issue_b,
  input  logic                     flush,
  output logic [N_UNITS-1:0]       fu_valid_in,
  output logic [WIDTH-1:0]         fu_a,
  output logic [WIDTH-1:0]         fu_b,
  input  logic [N_UNITS-1:0]       fu_valid_out,
  input  logic [N_UNITS*WIDTH-1:0] fu_result,
  output logic                     stall,
  output logic [WIDTH-1:0]         result,
  output logic                     result_valid,
  output logic [1:0]               err
);

  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_LAT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_err;

  logic             w_sel_ok;
  logic             w_fu_done;
  logic [WIDTH-1:0] w_fu_res;
  logic             w_timeout;
  logic             w_abort;

  assign w_sel_ok  = int'(issue_sel) < N_UNITS;
  assign w_timeout = (r_cnt == c_CNT_LAST);
  // A flush seen in IDLE is a no-op so it never blocks a same-cycle launch.
  assign w_abort   = flush && (r_state != c_IDLE);

  always_comb begin
    w_fu_done = 1'b0;
    w_fu_res  = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_fu_done = fu_valid_out[k];
        w_fu_res  = fu_result[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (issue_valid) w_next_state = w_sel_ok ? c_LAUNCH : c_DONE;
      c_LAUNCH: w_next_state = c_WAIT;
      c_WAIT:   if (w_fu_done || w_timeout) w_next_state = c_DONE;
      c_DONE:   w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = c_IDLE;
    end
  end

  always_comb begin
    stall        = 1'b0;
    result_valid = 1'b0;
    if (reset_n) begin
      stall        = (r_state == c_IDLE) ? issue_valid : (r_state != c_DONE);
      result_valid = (r_state == c_DONE) && !flush;
    end
  end

  for (genvar k = 0; k < N_UNITS; k++) begin : g_launch
    assign fu_valid_in[k] = (r_state == c_LAUNCH) && (r_sel == SEL_W'(k));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= '0;
    end else if (!w_abort) begin
      case (r_state)
        c_IDLE: begin
          if (issue_valid) begin
            if (w_sel_ok) begin
              r_sel <= issue_sel;
              r_a   <= issue_a;
              r_b   <= issue_b;
            end else begin
              r_err[1] <= 1'b1;
              r_result <= '0;
            end
          end
        end
        c_LAUNCH: r_cnt <= '0;
        c_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Completion beats timeout when both land in the same cycle.
          if (w_fu_done) begin
            r_result <= w_fu_res;
          end else if (w_timeout) begin
            r_err[0] <= 1'b1;
            r_result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign fu_a   = r_a;
  assign fu_b   = r_b;
  assign result = r_result;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_exec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_exec_ctrl
// Purpose  : Scoreboard bench with behavioural mult/div unit models.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_exec_ctrl;

  localparam int WIDTH   = 64;
  localparam int N_UNITS = 2;
  localparam int SEL_W   = 2;
  localparam int MAX_LAT = 8;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     issue_valid;
  logic [SEL_W-1:0]         issue_sel;
  logic [WIDTH-1:0]         issue_a;
  logic [WIDTH-1:0]         issue_b;
  logic                     flush;
  logic [N_UNITS-1:0]       fu_valid_in;
  logic [WIDTH-1:0]         fu_a;
  logic [WIDTH-1:0]         fu_b;
  logic [N_UNITS-1:0]       fu_valid_out;
  logic [N_UNITS*WIDTH-1:0] fu_result;
  logic                     stall;
  logic [WIDTH-1:0]         result;
  logic                     result_valid;
  logic [1:0]               err;

  always #5 clk = ~clk;

  multicycle_exec_ctrl #(
    .WIDTH   (WIDTH),
    .N_UNITS (N_UNITS),
    .SEL_W   (SEL_W),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_sel    (issue_sel),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .flush        (flush),
    .fu_valid_in  (fu_valid_in),
    .fu_a         (fu_a),
    .fu_b         (fu_b),
    .fu_valid_out (fu_valid_out),
    .fu_result    (fu_result),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  // Unit models: unit 0 multiplies, unit 1 divides (x/0 = all ones).
  // lat_cfg = 0 models a unit that never answers.
  int         lat_cfg [N_UNITS];
  int         u_rem   [N_UNITS];
  logic [63:0] u_res  [N_UNITS];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_UNITS; k++) begin
        u_rem[k] <= 0;
        u_res[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_UNITS; k++) begin
        if (fu_valid_in[k]) begin
          u_rem[k] <= lat_cfg[k];
          u_res[k] <= (k == 0) ? fu_a * fu_b : ((fu_b == 64'd0) ? '1 : fu_a / fu_b);
        end else if (u_rem[k] > 0) begin
          u_rem[k] <= u_rem[k] - 1;
        end
      end
    end
  end

  always_comb begin
    fu_valid_out = '0;
    for (int k = 0; k < N_UNITS; k++) fu_valid_out[k] = (u_rem[k] == 1);
  end
  assign fu_result = {u_res[1], u_res[0]};

  typedef struct {
    logic [63:0] res;
    logic [1:0]  err;
    int          done_cyc;
    int          dur;
  } exp_t;

  typedef struct {
    logic [1:0]  oh;
    logic [63:0] a;
    logic [63:0] b;
    int          cyc;
  } launch_t;

  exp_t        exp_q[$];
  launch_t     launch_q[$];
  exp_t        m_e;
  launch_t     m_l;
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          stall_run = 0;
  logic [1:0]  err_model = 2'b00;
  logic [63:0] last_res  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT launches or completes.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_run = 0;
    end else begin
      if (fu_valid_in != '0) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_launch", 64'(fu_valid_in), 64'd0);
        end else begin
          m_l = launch_q.pop_front();
          chk("launch_onehot", 64'(fu_valid_in), 64'(m_l.oh));
          chk("launch_fu_a", fu_a, m_l.a);
          chk("launch_fu_b", fu_b, m_l.b);
          chk("launch_cycle", 64'(cyc), 64'(m_l.cyc));
        end
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 64'(result_valid), 64'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("result", result, m_e.res);
          chk("err", 64'(err), 64'(m_e.err));
          chk("done_cycle", 64'(cyc), 64'(m_e.done_cyc));
          chk("stall_cycles", 64'(stall_run), 64'(m_e.dur));
          chk("stall_in_done", 64'(stall), 64'd0);
          last_res = m_e.res;
        end
        stall_run = 0;
      end else if (stall) begin
        stall_run++;
      end else begin
        stall_run = 0;
      end
    end
  end

  function automatic logic [63:0] unit_op(input int sel, input logic [63:0] a, input logic [63:0] b);
    if (sel == 0) return a * b;
    if (b == 64'd0) return '1;
    return a / b;
  endfunction

  // Presents one instruction and holds it until result_valid (pipeline view).
  task automatic issue_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input bit fl);
    exp_t    e;
    launch_t l;
    bit      got;
    @(posedge clk); #1;
    issue_valid = 1'b1;
    issue_sel   = 2'(sel);
    issue_a     = a;
    issue_b     = b;
    flush       = fl;
    if (sel >= N_UNITS) begin
      err_model[1] = 1'b1;
      e.res = '0;
      e.dur = 1;
    end else begin
      lat_cfg[sel] = lat;
      l.oh  = 2'(1 << sel);
      l.a   = a;
      l.b   = b;
      l.cyc = cyc + 1;
      launch_q.push_back(l);
      if (lat == 0 || lat > MAX_LAT) begin
        err_model[0] = 1'b1;
        e.res = '0;
        e.dur = MAX_LAT + 2;
      end else begin
        e.res = unit_op(sel, a, b);
        e.dur = lat + 2;
      end
    end
    e.err      = err_model;
    e.done_cyc = cyc + e.dur;
    exp_q.push_back(e);
    if (fl) begin
      @(posedge clk); #1;
      flush = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) got = 1'b1;
    end
    chk("op_completes", 64'(got), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      issue_valid = 1'b0;
      issue_sel   = 2'($urandom);
    end
  endtask

  // Launch an op, flush it wait_n cycles after issue, then watch it vanish.
  task automatic flush_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input int wait_n);
    launch_t l;
    @(posedge clk); #1;
    issue_valid  = 1'b1;
    issue_sel    = 2'(sel);
    issue_a      = a;
    issue_b      = b;
    lat_cfg[sel] = lat;
    l.oh  = 2'(1 << sel);
    l.a   = a;
    l.b   = b;
    l.cyc = cyc + 1;
    launch_q.push_back(l);
    repeat (wait_n) @(posedge clk);
    #1;
    flush       = 1'b1;
    issue_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (lat + 3) begin
      @(negedge clk);
      chk("flush_stall_low", 64'(stall), 64'd0);
      chk("flush_result_held", result, last_res);
    end
    chk("flush_err_unchanged", 64'(err), 64'(err_model));
  endtask

  initial begin
    int          sel;
    int          lat;
    int          gap;
    int          r;
    logic [63:0] a;
    logic [63:0] b;

    lat_cfg[0]  = 3;
    lat_cfg[1]  = 3;
    reset_n     = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b1;
    issue_sel   = 2'd0;
    issue_a     = 64'd5;
    issue_b     = 64'd5;
    repeat (2) @(negedge clk);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_fu_valid_in", 64'(fu_valid_in), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_result_valid", 64'(result_valid), 64'd0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    reset_n     = 1'b1;
    idle(2);

    issue_op(0, 64'd7, 64'd6, 3, 1'b0);
    idle(1);
    issue_op(1, 64'd100, 64'd7, MAX_LAT, 1'b0);
    issue_op(1, 64'd9, 64'd3, 2, 1'b0);
    idle(1);
    issue_op(3, 64'd1, 64'd2, 1, 1'b0);
    idle(1);
    issue_op(0, 64'd5, 64'd5, 0, 1'b0);
    idle(1);
    issue_op(0, 64'd12, 64'd13, 1, 1'b0);
    issue_op(1, 64'd50, 64'd5, MAX_LAT + 1, 1'b0);
    issue_op(0, 64'd3, 64'd9, 2, 1'b0);
    idle(1);

    flush_op(1, 64'd100, 64'd5, 6, 3);
    flush_op(0, 64'd3, 64'd4, 4, 1);
    issue_op(0, 64'd11, 64'd12, 2, 1'b1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      r   = int'($urandom_range(0, 9));
      sel = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      a   = {$urandom, $urandom};
      b   = (sel == 1 && $urandom_range(0, 3) != 0) ? 64'($urandom_range(0, 50))
                                                    : {$urandom, $urandom};
      lat = int'($urandom_range(0, 10));
      issue_op(sel, a, b, lat, 1'b0);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(12);

    @(posedge clk); #1;
    issue_valid = 1'b1;
    issue_sel   = 2'd0;
    issue_a     = 64'd21;
    issue_b     = 64'd2;
    lat_cfg[0]  = 6;
    m_l.oh  = 2'b01;
    m_l.a   = 64'd21;
    m_l.b   = 64'd2;
    m_l.cyc = cyc + 1;
    launch_q.push_back(m_l);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midop_reset_stall", 64'(stall), 64'd0);
    chk("midop_reset_fu_valid_in", 64'(fu_valid_in), 64'd0);
    chk("midop_reset_result", result, 64'd0);
    chk("midop_reset_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    reset_n     = 1'b1;
    err_model   = 2'b00;
    last_res    = '0;
    issue_op(1, 64'd81, 64'd9, 4, 1'b0);
    idle(15);

    chk("launch_queue_drained", 64'(launch_q.size()), 64'd0);
    chk("result_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
